move_ctrl: RTL and testbench
============================

MOVE_CTRL -- requirements
Module: move_ctrl

Interface
REQ-001 Parameter NB_PLAYERS, default 2: number of independently controlled players.
REQ-002 Parameter COORD_W, default 11: signed coordinate width.
REQ-003 Parameter SPEED_DIV, default 4: frames per update tick (>=1).
REQ-004 Parameter HOLD_TICKS, default 8: consecutive same-direction ticks before fast mode.
REQ-005 Parameter FAST_STEP, default 2: step size in fast mode.
REQ-006 Parameters X_MIN/X_MAX/Y_MIN/Y_MAX, defaults 0/799/0/599: inclusive position bounds.
REQ-007 Parameters START_X/START_Y, NB_PLAYERS*COORD_W packed, defaults p0=(100,300), p1=(700,300): reset positions.
REQ-008 clk  in  1  single system clock, all logic rising-edge.
REQ-009 reset_n  in  1  asynchronous active-low reset.
REQ-010 SOF  in  1  start-of-frame pulse, closes the update window.
REQ-011 EOF  in  1  end-of-frame pulse, opens the update window.
REQ-012 key  in  4*NB_PLAYERS  active-low keys per player: bit0 +X, bit1 +Y, bit2 -Y, bit3 -X.
REQ-013 center_x, center_y  out  COORD_W*NB_PLAYERS  signed player positions.
REQ-014 moving  out  NB_PLAYERS  player state is MOVE or FAST.
REQ-015 fast  out  NB_PLAYERS  player state is FAST.
REQ-016 tick  out  1  one-cycle pulse on the cycle positions update.

Function
REQ-017 Window flag: set by reset, cleared on EOF, set on SOF; EOF wins if both high.
REQ-018 Frame counter counts EOF pulses modulo SPEED_DIV, wraps SPEED_DIV-1 -> 0.
REQ-019 tick asserted the cycle after an EOF sampled with counter = SPEED_DIV-1, suppressed if SOF is high on that cycle.
REQ-020 Positions and states update only on the tick cycle; new values visible after that edge; at most one update per frame.
REQ-021 Valid key: exactly one key bit low; zero or several bits low = no key.
REQ-022 Per-player FSM IDLE/MOVE/FAST: IDLE->MOVE on valid key; MOVE->MOVE on same direction with hold count +1; direction change -> MOVE, count cleared; any state -> IDLE on no key, count cleared.
REQ-023 MOVE->FAST when hold count reaches HOLD_TICKS; FAST stays while direction unchanged.
REQ-024 Step applied on a tick uses the state before the tick: IDLE/MOVE step 1, FAST step FAST_STEP.
REQ-025 Arithmetic at COORD_W+1 bits signed; result saturates to [MIN,MAX] per axis, never wraps.
REQ-026 Players are fully independent; keys sampled only on the tick cycle.

Reset
REQ-027 On reset_n low: positions = START_X/START_Y, FSMs IDLE, hold counts 0, frame counter 0, window flag 1, tick/moving/fast 0.
REQ-028 Reset mid-window or mid-tick aborts the update; the first tick after reset requires SPEED_DIV full EOFs.

Configuration
REQ-029 Macro MOVE_CTRL_ACCEL_EN defined: FAST state and hold counters present per REQ-023/024.
REQ-030 Macro undefined: FSM is IDLE/MOVE only, step always 1, fast output tied 0, HOLD_TICKS/FAST_STEP unused.

Structure
REQ-031 Package move_ctrl_pkg holds the state enum, direction enum, key bit index constants.
REQ-032 Sub-module move_ctrl_player (FSM, hold counter, step, clamp) instantiated NB_PLAYERS times by generate; top holds window flag, frame counter, tick.

Verification
REQ-033 Reset, then 4 EOFs with key0=4'b1110 -> tick once, p0 x 100->101, p1 unchanged.
REQ-034 p0 +X held 9 ticks (ACCEL_EN) -> fast=1 after tick 8, tick 9 step 2: x=110.
REQ-035 p0 at x=798 in FAST, +X held -> x=799 and stays 799.
REQ-036 key0=4'b1100 (two keys) -> no move, moving=0, state IDLE.
REQ-037 SOF high on cycle after wrap EOF -> tick=0, positions unchanged.
REQ-038 reset_n low during tick cycle -> positions return to start values, counter 0.

Source files
------------

// File: rtl/move_ctrl_pkg.sv
// Shared types for move_ctrl: player state, move direction and active-low key bit positions.
package move_ctrl_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_FAST} state_t;
   typedef enum logic [1:0] {DIR_PX, DIR_PY, DIR_NY, DIR_NX} dir_t;

   localparam int KEY_PX = 0;
   localparam int KEY_PY = 1;
   localparam int KEY_NY = 2;
   localparam int KEY_NX = 3;

   // Keys are active low: a valid press is exactly one bit at 0.
   function automatic logic key_valid(input logic [3:0] k);
      return ($countones(~k) == 1);
   endfunction

   function automatic dir_t key_dir(input logic [3:0] k);
      if (!k[KEY_PX]) return DIR_PX;
      if (!k[KEY_PY]) return DIR_PY;
      if (!k[KEY_NY]) return DIR_NY;
      return DIR_NX;
   endfunction

endpackage

// File: rtl/move_ctrl_player.sv
// One player: IDLE/MOVE(/FAST) FSM, hold counter, step and per-axis saturation.
// FAST state and hold counter exist only when MOVE_CTRL_ACCEL_EN is defined.
module move_ctrl_player
   import move_ctrl_pkg::*;
#(
   parameter int COORD_W    = 11,
   parameter int HOLD_TICKS = 8,
   parameter int FAST_STEP  = 2,
   parameter int X_MIN      = 0,
   parameter int X_MAX      = 799,
   parameter int Y_MIN      = 0,
   parameter int Y_MAX      = 599,
   parameter logic [COORD_W-1:0] X0 = '0,
   parameter logic [COORD_W-1:0] Y0 = '0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               tick,
   input  logic [3:0]         key,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               moving,
   output logic               fast
);

   localparam logic signed [COORD_W:0] XL = (COORD_W+1)'(X_MIN);
   localparam logic signed [COORD_W:0] XH = (COORD_W+1)'(X_MAX);
   localparam logic signed [COORD_W:0] YL = (COORD_W+1)'(Y_MIN);
   localparam logic signed [COORD_W:0] YH = (COORD_W+1)'(Y_MAX);

   state_t                   state_reg, state_next;
   dir_t                     dir_reg, dir_next;
   logic                     key_ok;
   logic signed [COORD_W:0]  step, dx, dy, x_wide, y_wide;
   logic [COORD_W-1:0]       x_reg, y_reg, x_next, y_next;

   function automatic logic [COORD_W-1:0] clamp(input logic signed [COORD_W:0] v,
                                                input logic signed [COORD_W:0] lo,
                                                input logic signed [COORD_W:0] hi);
      if (v < lo) return lo[COORD_W-1:0];
      if (v > hi) return hi[COORD_W-1:0];
      return v[COORD_W-1:0];
   endfunction

`ifdef MOVE_CTRL_ACCEL_EN
   localparam int HW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
   localparam logic [HW-1:0] HT = HW'(HOLD_TICKS);
   logic [HW-1:0] hold_reg, hold_next;
`else
   localparam int unused_cfg = HOLD_TICKS + FAST_STEP;
`endif

   always_comb begin
      key_ok   = key_valid(key);
      dir_next = key_dir(key);
      step     = (COORD_W+1)'(1);
`ifdef MOVE_CTRL_ACCEL_EN
      // Step follows the state held before this tick, not the one being entered.
      if (state_reg == ST_FAST) step = (COORD_W+1)'(FAST_STEP);
`endif
      dx = '0;
      dy = '0;
      if (key_ok) begin
         case (dir_next)
            DIR_PX:  dx = step;
            DIR_NX:  dx = -step;
            DIR_PY:  dy = step;
            default: dy = -step;
         endcase
      end
      x_wide = $signed({x_reg[COORD_W-1], x_reg}) + dx;
      y_wide = $signed({y_reg[COORD_W-1], y_reg}) + dy;
      x_next = clamp(x_wide, XL, XH);
      y_next = clamp(y_wide, YL, YH);
`ifdef MOVE_CTRL_ACCEL_EN
      hold_next  = '0;
      state_next = ST_IDLE;
      if (key_ok) begin
         // The tick that starts a direction counts as its first held tick.
         if (state_reg != ST_IDLE && dir_next == dir_reg)
            hold_next = (hold_reg >= HT) ? hold_reg : hold_reg + 1'b1;
         else
            hold_next = HW'(1);
         state_next = (hold_next >= HT) ? ST_FAST : ST_MOVE;
      end
`else
      state_next = key_ok ? ST_MOVE : ST_IDLE;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         dir_reg   <= DIR_PX;
         x_reg     <= X0;
         y_reg     <= Y0;
`ifdef MOVE_CTRL_ACCEL_EN
         hold_reg  <= '0;
`endif
      end else if (tick) begin
         state_reg <= state_next;
         dir_reg   <= dir_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
`ifdef MOVE_CTRL_ACCEL_EN
         hold_reg  <= hold_next;
`endif
      end
   end

   assign x      = x_reg;
   assign y      = y_reg;
   assign moving = (state_reg != ST_IDLE);
`ifdef MOVE_CTRL_ACCEL_EN
   assign fast   = (state_reg == ST_FAST);
`else
   assign fast   = 1'b0;
`endif

endmodule

// File: rtl/move_ctrl.sv
// Frame-paced movement controller: window flag, EOF frame divider and update tick
// shared by NB_PLAYERS independent players. Acceleration is enabled by MOVE_CTRL_ACCEL_EN.
module move_ctrl
   import move_ctrl_pkg::*;
#(
   parameter int NB_PLAYERS = 2,
   parameter int COORD_W    = 11,
   parameter int SPEED_DIV  = 4,
   parameter int HOLD_TICKS = 8,
   parameter int FAST_STEP  = 2,
   parameter int X_MIN      = 0,
   parameter int X_MAX      = 799,
   parameter int Y_MIN      = 0,
   parameter int Y_MAX      = 599,
   parameter logic [NB_PLAYERS*COORD_W-1:0] START_X = {11'd700, 11'd100},
   parameter logic [NB_PLAYERS*COORD_W-1:0] START_Y = {11'd300, 11'd300}
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          SOF,
   input  logic                          EOF,
   input  logic [4*NB_PLAYERS-1:0]       key,
   output logic [COORD_W*NB_PLAYERS-1:0] center_x,
   output logic [COORD_W*NB_PLAYERS-1:0] center_y,
   output logic [NB_PLAYERS-1:0]         moving,
   output logic [NB_PLAYERS-1:0]         fast,
   output logic                          tick
);

   localparam int CW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SPEED_DIV - 1);

   logic          window_reg;
   logic          pend_reg;
   logic [CW-1:0] frame_cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         window_reg    <= 1'b1;
         pend_reg      <= 1'b0;
         frame_cnt_reg <= '0;
      end else begin
         if (EOF)
            window_reg <= 1'b0;
         else if (SOF)
            window_reg <= 1'b1;
         pend_reg <= EOF && (frame_cnt_reg == LAST);
         if (EOF)
            frame_cnt_reg <= (frame_cnt_reg == LAST) ? '0 : frame_cnt_reg + 1'b1;
      end
   end

   // A SOF arriving on the update cycle closes the window and drops this frame's update.
   assign tick = pend_reg && !window_reg && !SOF;

   for (genvar gi = 0; gi < NB_PLAYERS; gi++) begin : g_player
      move_ctrl_player #(
         .COORD_W    (COORD_W),
         .HOLD_TICKS (HOLD_TICKS),
         .FAST_STEP  (FAST_STEP),
         .X_MIN      (X_MIN),
         .X_MAX      (X_MAX),
         .Y_MIN      (Y_MIN),
         .Y_MAX      (Y_MAX),
         .X0         (START_X[gi*COORD_W +: COORD_W]),
         .Y0         (START_Y[gi*COORD_W +: COORD_W])
      ) u_player (
         .clk     (clk),
         .reset_n (reset_n),
         .tick    (tick),
         .key     (key[gi*4 +: 4]),
         .x       (center_x[gi*COORD_W +: COORD_W]),
         .y       (center_y[gi*COORD_W +: COORD_W]),
         .moving  (moving[gi]),
         .fast    (fast[gi])
      );
   end

endmodule

// File: tb/tb_move_ctrl.sv
// Directed bench for move_ctrl: tick pacing, movement, acceleration, saturation, SOF suppression, reset.
module tb_move_ctrl;

`ifdef MOVE_CTRL_ACCEL_EN
   localparam int ACCEL = 1;
`else
   localparam int ACCEL = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n, SOF, EOF, tick;
   logic [7:0]  key;
   logic [21:0] center_x, center_y;
   logic [1:0]  moving, fast;

   int n_tests = 0;
   int n_fail  = 0;

   move_ctrl dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .SOF      (SOF),
      .EOF      (EOF),
      .key      (key),
      .center_x (center_x),
      .center_y (center_y),
      .moving   (moving),
      .fast     (fast),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int px(input int p);
      return int'(center_x[p*11 +: 11]);
   endfunction

   function automatic int py(input int p);
      return int'(center_y[p*11 +: 11]);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One frame: EOF for one cycle, then one idle cycle; reports tick seen after the EOF.
   task automatic frame(output int seen);
      EOF = 1'b1;
      cyc();
      EOF = 1'b0;
      seen = int'(tick);
      cyc();
   endtask

   task automatic run_tick(output int nticks);
      int s;
      nticks = 0;
      for (int f = 0; f < 4; f++) begin
         frame(s);
         nticks += s;
      end
   endtask

   initial begin
      int nt, s, exp_x, loops, tick_sum;
      reset_n = 1'b0; SOF = 1'b0; EOF = 1'b0; key = 8'hFF;
      cyc(); cyc();
      check("rst_x0", px(0), 100);
      check("rst_y0", py(0), 300);
      check("rst_x1", px(1), 700);
      check("rst_y1", py(1), 300);
      check("rst_moving", int'(moving), 0);
      check("rst_fast", int'(fast), 0);
      check("rst_tick", int'(tick), 0);
      reset_n = 1'b1;
      cyc();

      // First +X tick for player 0 needs four EOFs
      key = 8'hFE;
      tick_sum = 0;
      for (int f = 0; f < 3; f++) begin
         frame(s);
         tick_sum += s;
      end
      check("no_tick_3eof", tick_sum, 0);
      check("x0_before_tick", px(0), 100);
      frame(s);
      check("tick_4th_eof", s, 1);
      check("x0_tick1", px(0), 101);
      check("x1_unchanged", px(1), 700);
      check("moving_tick1", int'(moving), 1);

      // Hold +X: fast after the 8th tick, 9th tick steps by FAST_STEP
      for (int t = 2; t <= 8; t++) run_tick(nt);
      check("x0_tick8", px(0), 108);
      check("fast_tick8", int'(fast), ACCEL);
      run_tick(nt);
      check("x0_tick9", px(0), ACCEL ? 110 : 109);

      // Keep holding up to 798, then saturate at 799
      exp_x = ACCEL ? 110 : 109;
      loops = 0;
      tick_sum = 0;
      while (exp_x < 798 && loops < 1000) begin
         run_tick(nt);
         tick_sum += nt;
         exp_x += ACCEL ? 2 : 1;
         loops++;
      end
      check("x0_at_798", px(0), 798);
      check("ticks_in_run", tick_sum, loops);
      run_tick(nt);
      check("x0_sat_799", px(0), 799);
      check("fast_at_edge", int'(fast), ACCEL);
      run_tick(nt);
      check("x0_stays_799", px(0), 799);

      // Two keys at once: no key
      key = 8'hFC;
      run_tick(nt);
      check("two_keys_x0", px(0), 799);
      check("two_keys_moving", int'(moving), 0);
      check("two_keys_fast", int'(fast), 0);

      // -Y on player 0, then p0 +Y while p1 moves -X
      key = 8'hFB;
      run_tick(nt);
      check("y0_minus", py(0), 299);
      key = 8'h7D;
      run_tick(nt);
      check("y0_plus", py(0), 300);
      check("x1_minus", px(1), 699);
      check("y1_unchanged", py(1), 300);
      check("moving_both", int'(moving), 3);

      // SOF on the update cycle suppresses the tick
      key = 8'h7F;
      for (int f = 0; f < 3; f++) frame(s);
      EOF = 1'b1;
      cyc();
      EOF = 1'b0;
      SOF = 1'b1;
      #1;
      check("sof_tick_low", int'(tick), 0);
      cyc();
      SOF = 1'b0;
      cyc();
      check("sof_x1_hold", px(1), 699);
      run_tick(nt);
      check("after_sof_tick", nt, 1);
      check("after_sof_x1", px(1), 698);

      // Reset during the tick cycle aborts the update and restarts the divider
      for (int f = 0; f < 3; f++) frame(s);
      EOF = 1'b1;
      cyc();
      EOF = 1'b0;
      check("pre_reset_tick", int'(tick), 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_x0", px(0), 100);
      check("mid_rst_x1", px(1), 700);
      check("mid_rst_tick", int'(tick), 0);
      cyc();
      reset_n = 1'b1;
      cyc();
      tick_sum = 0;
      for (int f = 0; f < 3; f++) begin
         frame(s);
         tick_sum += s;
      end
      check("rst_cnt_zero", tick_sum, 0);
      check("rst_x1_hold", px(1), 700);
      frame(s);
      check("rst_first_tick", s, 1);
      check("rst_x1_moved", px(1), 699);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
